// File: rtl/video_line_scaler_buffer.sv
// Multi-line video buffer between the pixel cores and the VGA stage.
// Each stored line is replayed 1-4 times for integer vertical upscaling.
module video_line_scaler_buffer #(
  parameter int RGB_SIZE  = 12,
  parameter int H_RES     = 640,
  parameter int NUM_LINES = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [1:0]                    cfg_vrep,
  input  logic [RGB_SIZE:0]             src_data,
  input  logic                          src_vld,
  output logic                          src_rdy,
  output logic [RGB_SIZE:0]             snk_data,
  output logic                          snk_vld,
  input  logic                          snk_rdy,
  output logic [$clog2(NUM_LINES):0]    lines_used,
  output logic                          sof_err,
  input  logic                          sof_err_clr
);

  localparam int DW     = RGB_SIZE + 1;
  localparam int SLOT_W = $clog2(NUM_LINES);
  localparam int COL_W  = $clog2(H_RES);
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_RES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_LINES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  logic [DW-1:0]     line_mem [NUM_LINES][H_RES];
  logic [DW-1:0]     rd_data_q;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [1:0]        rep_q, rep_d, rep_max_q, rep_max_d;
  logic [CNT_W-1:0]  lines_used_q, lines_used_d;
  logic              src_rdy_q, src_rdy_d;
  logic              sof_err_q, sof_err_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_rep0_q, rd_rep0_d;
  logic [DW-1:0]     skid0_q, skid0_d, skid1_q, skid1_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic              snk_vld_q, snk_vld_d;

  logic              src_fire, resync, commit;
  logic [COL_W-1:0]  wr_col_eff;
  logic              snk_pop, start, playing, room, rd_issue, line_end, release_line;
  logic [COL_W-1:0]  cur_col;
  logic [1:0]        cur_rep, cur_max;
  logic [DW-1:0]     rd_word;

  // Write-side addressing, commit and frame_start resynchronisation.
  always_comb begin
    src_fire   = src_vld && src_rdy_q;
    resync     = src_fire && src_data[RGB_SIZE] && (wr_col_q != '0);
    wr_col_eff = resync ? '0 : wr_col_q;
    commit     = src_fire && !resync && (wr_col_q == LAST_COL);
    wr_slot_d  = wr_slot_q;
    wr_col_d   = wr_col_q;
    if (!src_fire) begin
      wr_col_d = wr_col_q;
    end else if (resync) begin
      wr_col_d = COL_W'(1);
    end else if (commit) begin
      wr_col_d  = '0;
      wr_slot_d = wr_slot_q + SLOT_W'(1);
    end else begin
      wr_col_d = wr_col_q + COL_W'(1);
    end
    if (resync) begin
      sof_err_d = 1'b1;
    end else if (sof_err_clr) begin
      sof_err_d = 1'b0;
    end else begin
      sof_err_d = sof_err_q;
    end
  end

  // Read-side sequencing: replay count, slot release and RAM read issue.
  always_comb begin
    snk_pop  = snk_vld_q && snk_rdy;
    start    = (state_q == ST_IDLE) && (lines_used_q != '0);
    playing  = (state_q == ST_PLAY) || start;
    // In IDLE the first read is issued on the same edge as the line start.
    cur_col  = start ? '0 : rd_col_q;
    cur_rep  = start ? 2'd0 : rep_q;
    cur_max  = start ? cfg_vrep : rep_max_q;
    room     = ({1'b0, skid_cnt_q} + {2'b00, rd_pend_q}) <= (3'd1 + {2'b00, snk_pop});
    rd_issue = playing && room;
    line_end = rd_issue && (cur_col == LAST_COL);
    release_line = line_end && (cur_rep == cur_max);
    lines_used_d = lines_used_q + {{(CNT_W-1){1'b0}}, commit}
                                - {{(CNT_W-1){1'b0}}, release_line};
    src_rdy_d = lines_used_d < FULL_CNT;
    rd_pend_d = rd_issue;
    rd_rep0_d = rd_issue ? (cur_rep == 2'd0) : rd_rep0_q;

    state_d   = state_q;
    rd_slot_d = rd_slot_q;
    rd_col_d  = rd_col_q;
    rep_d     = rep_q;
    rep_max_d = rep_max_q;
    if (start) begin
      state_d   = ST_PLAY;
      rep_d     = 2'd0;
      rep_max_d = cfg_vrep;
      rd_col_d  = '0;
    end else begin
      state_d = state_q;
    end
    if (!rd_issue) begin
      rd_col_d = rd_col_d;
    end else if (!line_end) begin
      rd_col_d = cur_col + COL_W'(1);
    end else if (!release_line) begin
      rd_col_d = '0;
      rep_d    = cur_rep + 2'd1;
    end else begin
      rd_col_d  = '0;
      rep_d     = 2'd0;
      rd_slot_d = rd_slot_q + SLOT_W'(1);
      if (lines_used_d != '0) begin
        state_d   = ST_PLAY;
        rep_max_d = cfg_vrep;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Two-entry output skid; replays suppress the stored frame_start bit.
  always_comb begin
    rd_word    = {rd_data_q[RGB_SIZE] & rd_rep0_q, rd_data_q[RGB_SIZE-1:0]};
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case (skid_cnt_q)
      2'd0: begin
        if (rd_pend_q) begin
          skid0_d    = rd_word;
          skid_cnt_d = 2'd1;
        end else begin
          skid_cnt_d = 2'd0;
        end
      end
      2'd1: begin
        if (rd_pend_q && snk_pop) begin
          skid0_d = rd_word;
        end else if (rd_pend_q) begin
          skid1_d    = rd_word;
          skid_cnt_d = 2'd2;
        end else if (snk_pop) begin
          skid_cnt_d = 2'd0;
        end else begin
          skid_cnt_d = 2'd1;
        end
      end
      2'd2: begin
        if (snk_pop) begin
          skid0_d = skid1_q;
          if (rd_pend_q) begin
            skid1_d = rd_word;
          end else begin
            skid_cnt_d = 2'd1;
          end
        end else begin
          skid_cnt_d = 2'd2;
        end
      end
      default: skid_cnt_d = 2'd0;
    endcase
    snk_vld_d = (skid_cnt_d != 2'd0);
  end

  // Line storage with one-cycle synchronous read.
  always_ff @(posedge sys_clk) begin
    if (src_fire) begin
      line_mem[wr_slot_q][wr_col_eff] <= src_data;
    end
    if (rd_issue) begin
      rd_data_q <= line_mem[rd_slot_q][cur_col];
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      wr_slot_q    <= '0;
      wr_col_q     <= '0;
      rd_slot_q    <= '0;
      rd_col_q     <= '0;
      rep_q        <= 2'd0;
      rep_max_q    <= 2'd0;
      lines_used_q <= '0;
      src_rdy_q    <= 1'b0;
      sof_err_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_rep0_q    <= 1'b0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      skid_cnt_q   <= 2'd0;
      snk_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_slot_q    <= wr_slot_d;
      wr_col_q     <= wr_col_d;
      rd_slot_q    <= rd_slot_d;
      rd_col_q     <= rd_col_d;
      rep_q        <= rep_d;
      rep_max_q    <= rep_max_d;
      lines_used_q <= lines_used_d;
      src_rdy_q    <= src_rdy_d;
      sof_err_q    <= sof_err_d;
      rd_pend_q    <= rd_pend_d;
      rd_rep0_q    <= rd_rep0_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      skid_cnt_q   <= skid_cnt_d;
      snk_vld_q    <= snk_vld_d;
    end
  end

  assign src_rdy    = src_rdy_q;
  assign snk_data   = skid0_q;
  assign snk_vld    = snk_vld_q;
  assign lines_used = lines_used_q;
  assign sof_err    = sof_err_q;

endmodule
